// File: rtl/input_loader_pkg.sv
// Shared types for the input loader: FSM encoding, lane geometry and bus widths.
// Imported by the interface, the lane adder and the loader top.
package loader_pkg;

  localparam int LANE_W = 16;
  localparam int LANE_N = 8;
  localparam int WORD_W = LANE_W * LANE_N;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/input_loader_if.sv
// Control, input-memory read and scratchpad write signals of the input loader.
// master is the loader side; slave is the memory/scratchpad/controller side.
interface input_loader_if;
  import loader_pkg::*;

  logic  start;
  addr_t Input_MEMAddress;
  logic  Input_ReadEnable;
  word_t Input_MEMBus;
  logic  SP_WriteEnable;
  addr_t SP_WriteAddress;
  word_t SP_WriteBus;
  lane_t Checksum;
  logic  busy;
  logic  done;

  modport master (
    input  start,
    input  Input_MEMBus,
    output Input_MEMAddress,
    output Input_ReadEnable,
    output SP_WriteEnable,
    output SP_WriteAddress,
    output SP_WriteBus,
    output Checksum,
    output busy,
    output done
  );

  modport slave (
    output start,
    output Input_MEMBus,
    input  Input_MEMAddress,
    input  Input_ReadEnable,
    input  SP_WriteEnable,
    input  SP_WriteAddress,
    input  SP_WriteBus,
    input  Checksum,
    input  busy,
    input  done
  );

endinterface

// File: rtl/input_loader_lane_adder8.sv
// Combinational modulo-2^16 sum of the eight 16-bit lanes of one 128-bit word.
module lane_adder8
  import loader_pkg::*;
(
  input  word_t word,
  output lane_t sum
);

  // Lane accumulation; carries out of bit 15 are dropped on purpose.
  always_comb begin
    sum = {LANE_W{1'b0}};
    for (int i = 0; i < LANE_N; i++) begin
      sum = sum + word[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/input_loader.sv
// Streams NUM_WORDS 128-bit words from input memory into the scratchpad,
// keeping a 16-bit lane checksum of everything written during the run.
module input_loader
  import loader_pkg::*;
#(
  parameter logic [15:0] IN_BASE   = 16'h0000,
  parameter logic [15:0] SP_BASE   = 16'h0000,
  parameter logic [15:0] NUM_WORDS = 16'd64
) (
  input logic            clock,
  input logic            reset_n,
  input_loader_if.master bus
);

  state_e state_r;
  addr_t  rd_left_r;
  logic   drain_r;
  addr_t  rd_addr_r;
  logic   rd_en_r;
  logic   rd_vld_r;
  logic   wr_en_r;
  addr_t  wr_addr_r;
  addr_t  wr_ptr_r;
  word_t  wr_data_r;
  lane_t  checksum_r;
  logic   busy_r;
  logic   done_r;
  logic   accept_s;
  lane_t  lane_sum_s;

  lane_adder8 u_lane_adder8 (
    .word (wr_data_r),
    .sum  (lane_sum_s)
  );

  // A start is only honoured while idle.
  always_comb begin
    accept_s = 1'b0;
    if ((state_r == ST_IDLE) && bus.start) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Run sequencing: read issue, two-cycle drain, done pulse and checksum.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      rd_left_r  <= 16'h0000;
      drain_r    <= 1'b0;
      rd_addr_r  <= 16'h0000;
      rd_en_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      checksum_r <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            busy_r <= 1'b1;
            if (NUM_WORDS == 16'd0) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r   <= ST_READ;
              rd_en_r   <= 1'b1;
              rd_addr_r <= IN_BASE;
              rd_left_r <= NUM_WORDS - 16'd1;
            end
          end
        end
        ST_READ: begin
          if (rd_left_r == 16'd0) begin
            state_r <= ST_DRAIN;
            rd_en_r <= 1'b0;
            drain_r <= 1'b0;
          end else begin
            rd_addr_r <= rd_addr_r + 16'd1;
            rd_left_r <= rd_left_r - 16'd1;
          end
        end
        // Last read needs one cycle for memory latency and one for the write.
        ST_DRAIN: begin
          if (drain_r) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            drain_r <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          rd_en_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase

      if (accept_s) begin
        checksum_r <= 16'h0000;
      end else if (wr_en_r) begin
        checksum_r <= checksum_r + lane_sum_s;
      end
    end
  end

  // Write pipeline: capture read data one cycle after the strobe, write it next.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_r  <= 1'b0;
      wr_en_r   <= 1'b0;
      wr_ptr_r  <= 16'h0000;
      wr_addr_r <= 16'h0000;
      wr_data_r <= {WORD_W{1'b0}};
    end else begin
      rd_vld_r <= rd_en_r;
      wr_en_r  <= rd_vld_r;
      if (accept_s) begin
        wr_ptr_r <= SP_BASE;
      end else if (rd_vld_r) begin
        wr_ptr_r <= wr_ptr_r + 16'd1;
      end
      if (rd_vld_r) begin
        wr_addr_r <= wr_ptr_r;
        wr_data_r <= bus.Input_MEMBus;
      end
    end
  end

  assign bus.Input_MEMAddress = rd_addr_r;
  assign bus.Input_ReadEnable = rd_en_r;
  assign bus.SP_WriteEnable   = wr_en_r;
  assign bus.SP_WriteAddress  = wr_addr_r;
  assign bus.SP_WriteBus      = wr_data_r;
  assign bus.Checksum         = checksum_r;
  assign bus.busy             = busy_r;
  assign bus.done             = done_r;

endmodule
